// File: rtl/ysyx_25020037_axi_pkg.sv
// Shared definitions for the core-side AXI4 arbiter.
// Holds the arbiter state encoding and the AXI response/burst constants.
package ysyx_25020037_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_IFU = 2'd1,
    ST_RD_LSU = 2'd2,
    ST_WR     = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

endpackage

// File: rtl/ysyx_25020037_arb_prio.sv
// Fixed-priority grant encoder for the AXI arbiter.
// Ports:
//   wr_req_i     - LSU write pending (AW or W valid), highest priority
//   lsu_rd_req_i - LSU read pending
//   ifu_rd_req_i - IFU read pending, lowest priority
//   grant_o      - state to enter next; ST_IDLE when nothing is pending
module ysyx_25020037_arb_prio
  import ysyx_25020037_axi_pkg::*;
(
  input  logic       wr_req_i,
  input  logic       lsu_rd_req_i,
  input  logic       ifu_rd_req_i,
  output arb_state_e grant_o
);

  always_comb begin
    grant_o = ST_IDLE;
    if (wr_req_i)          grant_o = ST_WR;
    else if (lsu_rd_req_i) grant_o = ST_RD_LSU;
    else if (ifu_rd_req_i) grant_o = ST_RD_IFU;
  end

endmodule

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Shares one AXI4 master port between the IFU (read only) and the LSU
// (read + single-beat write). One transaction in flight; the grant is held
// from arbitration until the final R beat or the B handshake.
// Ports:
//   clk, rst            - core clock, synchronous active-high reset
//   ifu_ar*/ifu_r*      - IFU read address / read data channels
//   lsu_ar*/lsu_r*      - LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b* - LSU write address / data / response channels
//   m_*                 - downstream AXI4 master port
//   err_len             - sticky: an rlast arrived at a beat count != arlen
module ysyx_25020037_axi_arbiter
  import ysyx_25020037_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [ID_W-1:0]     ifu_arid,
  input  logic [LEN_W-1:0]    ifu_arlen,
  input  logic [SIZE_W-1:0]   ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  output logic [ID_W-1:0]     ifu_rid,
  input  logic                ifu_rready,
  // LSU read
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [ID_W-1:0]     lsu_arid,
  input  logic [LEN_W-1:0]    lsu_arlen,
  input  logic [SIZE_W-1:0]   lsu_arsize,
  input  logic [1:0]          lsu_arburst,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rlast,
  output logic [ID_W-1:0]     lsu_rid,
  input  logic                lsu_rready,
  // LSU write
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [ID_W-1:0]     lsu_awid,
  input  logic [LEN_W-1:0]    lsu_awlen,
  input  logic [SIZE_W-1:0]   lsu_awsize,
  input  logic [1:0]          lsu_awburst,
  output logic                lsu_awready,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  output logic [ID_W-1:0]     lsu_bid,
  input  logic                lsu_bready,
  // downstream master
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [ID_W-1:0]     m_arid,
  output logic [LEN_W-1:0]    m_arlen,
  output logic [SIZE_W-1:0]   m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic [ID_W-1:0]     m_rid,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W-1:0]     m_awid,
  output logic [LEN_W-1:0]    m_awlen,
  output logic [SIZE_W-1:0]   m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  input  logic [ID_W-1:0]     m_bid,
  output logic                err_len
);

  arb_state_e        state_q, state_d, grant;
  logic              ar_done_q, ar_done_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_len_q, err_len_d;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;

  ysyx_25020037_arb_prio u_prio (
    .wr_req_i     (lsu_awvalid | lsu_wvalid),
    .lsu_rd_req_i (lsu_arvalid),
    .ifu_rd_req_i (ifu_arvalid),
    .grant_o      (grant)
  );

  assign ar_hs   = m_arvalid & m_arready;
  assign r_hs    = m_rvalid  & m_rready;
  assign aw_hs   = m_awvalid & m_awready;
  assign w_hs    = m_wvalid  & m_wready;
  assign b_hs    = m_bvalid  & m_bready;
  assign err_len = err_len_q;

  // Channel steering. Everything defaults to 0 so IDLE and the non-granted
  // master see quiet channels.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rid     = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_rid     = '0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    lsu_bid     = '0;
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_arid      = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arburst   = '0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_awaddr    = '0;
    m_awid      = '0;
    m_awlen     = '0;
    m_awsize    = '0;
    m_awburst   = '0;
    m_wvalid    = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    unique case (state_q)
      ST_RD_IFU: begin
        // ar_done gates the request so a master still holding arvalid
        // cannot issue a second AR within the same transaction.
        m_arvalid   = ifu_arvalid & ~ar_done_q;
        m_araddr    = ifu_araddr;
        m_arid      = ifu_arid;
        m_arlen     = ifu_arlen;
        m_arsize    = ifu_arsize;
        m_arburst   = ifu_arburst;
        ifu_arready = m_arready & ~ar_done_q;
        ifu_rvalid  = m_rvalid;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        ifu_rid     = m_rid;
        m_rready    = ifu_rready;
      end
      ST_RD_LSU: begin
        m_arvalid   = lsu_arvalid & ~ar_done_q;
        m_araddr    = lsu_araddr;
        m_arid      = lsu_arid;
        m_arlen     = lsu_arlen;
        m_arsize    = lsu_arsize;
        m_arburst   = lsu_arburst;
        lsu_arready = m_arready & ~ar_done_q;
        lsu_rvalid  = m_rvalid;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rlast   = m_rlast;
        lsu_rid     = m_rid;
        m_rready    = lsu_rready;
      end
      ST_WR: begin
        m_awvalid   = lsu_awvalid & ~aw_done_q;
        m_awaddr    = lsu_awaddr;
        m_awid      = lsu_awid;
        m_awlen     = lsu_awlen;
        m_awsize    = lsu_awsize;
        m_awburst   = lsu_awburst;
        lsu_awready = m_awready & ~aw_done_q;
        m_wvalid    = lsu_wvalid & ~w_done_q;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wlast     = lsu_wlast;
        lsu_wready  = m_wready & ~w_done_q;
        lsu_bvalid  = m_bvalid;
        lsu_bresp   = m_bresp;
        lsu_bid     = m_bid;
        m_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

  // Next state and bookkeeping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:              state_d = grant;
      ST_RD_IFU, ST_RD_LSU: if (r_hs && m_rlast) state_d = ST_IDLE;
      ST_WR:                if (b_hs) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase

    // Completion flags and the beat counter all clear on return to IDLE.
    ar_done_d  = (state_d == ST_IDLE) ? 1'b0 : (ar_done_q | ar_hs);
    aw_done_d  = (state_d == ST_IDLE) ? 1'b0 : (aw_done_q | aw_hs);
    w_done_d   = (state_d == ST_IDLE) ? 1'b0 : (w_done_q | w_hs);
    beat_cnt_d = (state_d == ST_IDLE) ? '0 : beat_cnt_q + LEN_W'(r_hs);

    // arlen is captured at the AR handshake: the requester is free to change
    // its AR fields once accepted, but the length check needs the original.
    len_d      = ar_hs ? m_arlen : len_q;
    // beat_cnt holds the index of the current beat, which must equal arlen
    // on the last one.
    err_len_d  = err_len_q | (r_hs & m_rlast & (beat_cnt_q != len_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ar_done_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_done_q  <= ar_done_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      err_len_q  <= err_len_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
module tb_ysyx_25020037_axi_arbiter;

  logic        clk, rst;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [3:0]  ifu_arid, ifu_rid;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst, ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [3:0]  lsu_arid, lsu_rid;
  logic [7:0]  lsu_arlen;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_arburst, lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
  logic [7:0]  lsu_awlen;
  logic [2:0]  lsu_awsize;
  logic [1:0]  lsu_awburst, lsu_bresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb, m_bid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;
  logic        err_len;

  int checks = 0;
  int errors = 0;

  ysyx_25020037_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
    .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
    .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
    .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid), .lsu_bready(lsu_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_bid(m_bid), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle inputs/outputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ifu_req(input logic [31:0] addr, input logic [7:0] len);
    ifu_arvalid = 1'b1; ifu_araddr = addr; ifu_arlen = len;
    ifu_arid = 4'd2; ifu_arsize = 3'd2; ifu_arburst = 2'd1;
  endtask

  task automatic rbeat(input logic [31:0] data, input logic last);
    m_rvalid = 1'b1; m_rdata = data; m_rlast = last; m_rresp = 2'd0; m_rid = 4'd2;
  endtask

  initial begin
    rst = 1'b1;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_arburst = 0;
    ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_arburst = 0;
    lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = 0; lsu_awid = 0; lsu_awlen = 0; lsu_awsize = 0; lsu_awburst = 0;
    lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0; lsu_bready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rid = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
    tick(); tick();
    rst = 1'b0;

    // ---- reset state
    chk("rst_state", dut.state_q, 0);
    chk("rst_beat_cnt", dut.beat_cnt_q, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_m_arvalid", m_arvalid, 0);

    // ---- IFU single read
    m_arready = 1; m_awready = 1; m_wready = 1;
    ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
    ifu_req(32'h3000_0000, 8'd0);
    #1;
    chk("t1_arb_cycle_arvalid", m_arvalid, 0);
    chk("t1_arb_cycle_arready", ifu_arready, 0);
    tick();
    chk("t1_state", dut.state_q, 1);
    chk("t1_m_arvalid", m_arvalid, 1);
    chk("t1_m_araddr", m_araddr, 32'h3000_0000);
    chk("t1_ifu_arready", ifu_arready, 1);
    tick();
    chk("t1_ar_done_gate", m_arvalid, 0);
    ifu_arvalid = 0;
    rbeat(32'hDEAD_BEEF, 1'b1);
    #1;
    chk("t1_ifu_rvalid", ifu_rvalid, 1);
    chk("t1_ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
    chk("t1_ifu_rid", ifu_rid, 2);
    chk("t1_lsu_rvalid", lsu_rvalid, 0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    chk("t1_back_idle", dut.state_q, 0);

    // ---- IFU 4-beat burst, LSU read arrives during beat 1
    ifu_req(32'hA000_0000, 8'd3);
    tick();
    chk("t2_m_arlen", m_arlen, 3);
    tick();
    ifu_arvalid = 0;
    rbeat(32'h100, 1'b0);
    tick();
    rbeat(32'h101, 1'b0);
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0010; lsu_arlen = 0; lsu_arid = 4'd7;
    #1;
    chk("t2_lsu_stalled", lsu_arready, 0);
    chk("t2_state_ifu", dut.state_q, 1);
    chk("t2_beat_cnt", dut.beat_cnt_q, 1);
    tick();
    rbeat(32'h102, 1'b0);
    tick();
    rbeat(32'h103, 1'b1);
    #1;
    chk("t2_last_rdata", ifu_rdata, 32'h103);
    chk("t2_last_rlast", ifu_rlast, 1);
    tick();
    m_rvalid = 0; m_rlast = 0;
    chk("t2_idle_after_last", dut.state_q, 0);
    chk("t2_idle_arvalid", m_arvalid, 0);
    chk("t2_err_len", err_len, 0);
    tick();
    chk("t2_lsu_granted", dut.state_q, 2);
    chk("t2_lsu_m_araddr", m_araddr, 32'h8000_0010);
    chk("t2_lsu_arready", lsu_arready, 1);
    tick();
    lsu_arvalid = 0;
    rbeat(32'h55, 1'b1);
    #1;
    chk("t2_lsu_rdata", lsu_rdata, 32'h55);
    chk("t2_ifu_rvalid_off", ifu_rvalid, 0);
    tick();
    m_rvalid = 0; m_rlast = 0;

    // ---- simultaneous requests: WR, then RD_LSU, then RD_IFU
    ifu_req(32'h0000_1000, 8'd0);
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0020; lsu_arlen = 0;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0040; lsu_awid = 4'd5;
    lsu_wvalid = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF; lsu_wlast = 1;
    tick();
    chk("t3_wr_first", dut.state_q, 3);
    chk("t3_m_awvalid", m_awvalid, 1);
    chk("t3_m_wdata", m_wdata, 32'hCAFE_F00D);
    chk("t3_no_ar", m_arvalid, 0);
    tick();
    lsu_awvalid = 0; lsu_wvalid = 0;
    m_bvalid = 1; m_bresp = 2'd0; m_bid = 4'd5;
    #1;
    chk("t3_lsu_bvalid", lsu_bvalid, 1);
    tick();
    m_bvalid = 0;
    chk("t3_wr_done_idle", dut.state_q, 0);
    tick();
    chk("t3_rd_lsu_second", dut.state_q, 2);
    chk("t3_ifu_blocked", ifu_arready, 0);
    tick();
    lsu_arvalid = 0;
    rbeat(32'h77, 1'b1);
    tick();
    m_rvalid = 0; m_rlast = 0;
    tick();
    chk("t3_rd_ifu_third", dut.state_q, 1);
    chk("t3_ifu_m_araddr", m_araddr, 32'h0000_1000);
    tick();
    ifu_arvalid = 0;
    rbeat(32'h88, 1'b1);
    tick();
    m_rvalid = 0; m_rlast = 0;

    // ---- write with W before AW, SLVERR response
    lsu_wvalid = 1; lsu_wdata = 32'h1234_5678;
    tick();
    chk("t4_wr_state", dut.state_q, 3);
    chk("t4_w_fwd", m_wvalid, 1);
    chk("t4_aw_idle", m_awvalid, 0);
    tick();
    lsu_wvalid = 0;
    chk("t4_w_done_gate", m_wvalid, 0);
    tick();
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0080; lsu_awid = 4'd5;
    #1;
    chk("t4_aw_fwd", m_awvalid, 1);
    chk("t4_w_still_gated", lsu_wready, 0);
    tick();
    lsu_awvalid = 0;
    m_bvalid = 1; m_bresp = 2'd2; m_bid = 4'd5;
    #1;
    chk("t4_bresp", lsu_bresp, 2);
    chk("t4_bid", lsu_bid, 5);
    tick();
    m_bvalid = 0; m_bresp = 0;
    chk("t4_idle", dut.state_q, 0);

    // ---- reset during beat 2 of a 4-beat burst
    ifu_req(32'hA000_0100, 8'd3);
    tick(); tick();
    ifu_arvalid = 0;
    rbeat(32'h200, 1'b0);
    tick();
    rbeat(32'h201, 1'b0);
    tick();
    rbeat(32'h202, 1'b0);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_state", dut.state_q, 0);
    chk("t5_beat_cnt", dut.beat_cnt_q, 0);
    chk("t5_ifu_rvalid", ifu_rvalid, 0);
    chk("t5_m_rready", m_rready, 0);
    chk("t5_m_arvalid", m_arvalid, 0);
    chk("t5_ifu_arready", ifu_arready, 0);
    m_rvalid = 0;

    // ---- early rlast on beat 2 of a len=3 burst
    ifu_req(32'hA000_0200, 8'd3);
    tick(); tick();
    ifu_arvalid = 0;
    rbeat(32'h300, 1'b0);
    tick();
    rbeat(32'h301, 1'b0);
    tick();
    rbeat(32'h302, 1'b1);
    chk("t6_err_before", err_len, 0);
    tick();
    m_rvalid = 0; m_rlast = 0;
    chk("t6_err_len", err_len, 1);
    chk("t6_idle", dut.state_q, 0);
    tick();
    chk("t6_err_sticky", err_len, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_axi_arbiter.md
# ysyx_25020037_axi_arbiter

Shares the core's single AXI4 master port between the instruction fetch unit and the load/store unit. Sits between the IFU/LSU AXI masters and the SoC crossbar. Allows one outstanding transaction at a time. It arbitrates with fixed priority, locks the grant for a whole transaction (including bursts) and steers response channels back only to the granted requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all AR/AW channels
- `DATA_W`, 32, data width of R/W channels

Ports (`x{a,b}` lists signals sharing one channel; widths are in the same order):
- `clk`  in  1  single core clock
- `rst`  in  1  synchronous, active-high reset
- `ifu_ar{valid,addr,id,len,size,burst}`  in  1/32/4/8/3/2  IFU read address request
- `ifu_arready`  out  1  AR accepted by the downstream port for the IFU
- `ifu_r{valid,data,resp,last,id}`  out  1/32/2/1/4  read data to the IFU
- `ifu_rready`  in  1  IFU accepts a read beat
- `lsu_ar{valid,addr,id,len,size,burst}`  in  1/32/4/8/3/2  LSU read address request
- `lsu_arready`  out  1  LSU AR accepted
- `lsu_r{valid,data,resp,last,id}`  out  1/32/2/1/4  read data to the LSU
- `lsu_rready`  in  1  LSU accepts a read beat
- `lsu_aw{valid,addr,id,len,size,burst}`  in  1/32/4/8/3/2  LSU write address
- `lsu_awready`  out  1  LSU write address accepted
- `lsu_w{valid,data,strb,last}`  in  1/32/4/1  LSU write data, single beat
- `lsu_wready`  out  1  LSU write data accepted
- `lsu_b{valid,resp,id}`  out  1/2/4  LSU write response
- `lsu_bready`  in  1  LSU accepts the write response
- `m_*`  mixed  AXI4  downstream master port: full AR/R/AW/W/B channels with the same fields and widths as above

## Operation
- States:
  - IDLE
  - RD_IFU
  - RD_LSU
  - WR
- IDLE:
  - All downstream valids and all upstream readies/valids are 0.
  - Priority for the next cycle's state: `lsu_awvalid|lsu_wvalid` → WR; else `lsu_arvalid` → RD_LSU; else `ifu_arvalid` → RD_IFU.
- RD_x:
  - `m_ar*` is a combinational copy of master x's AR; `x_arready = m_arready`.
  - Register `ar_done` is set on the AR handshake. Once it is set, `m_arvalid` is forced to 0.
  - `m_r*` goes to x only. `m_rready = x_rready`. The other master's `rvalid` is 0.
  - A handshake with `m_rlast=1` returns the FSM to IDLE and clears `ar_done`.
  - `rresp` is passed through unmodified. A SLVERR/DECERR beat still ends the transaction on `rlast`.
- WR:
  - AW and W are forwarded combinationally, gated by registers `aw_done` and `w_done` (each set on its own handshake).
  - AW and W may complete in either order or in the same cycle.
  - The B handshake returns the FSM to IDLE and clears both flags.
  - `m_bready = lsu_bready`.
- Non-granted masters see their ready = 0 and may hold valid indefinitely. No request is dropped.
- A master that deasserts valid before its handshake violates the protocol. The arbiter keeps its grant regardless.
- 8-bit beat counter `beat_cnt`:
  - Increments on each R handshake and clears on IDLE entry.
  - `rlast` arriving when `beat_cnt != arlen` sets sticky `err_len` (internal, exported for assertion only).

## Timing
- Arbitration costs exactly 1 cycle: a request in IDLE at cycle N → `m_arvalid`/`m_awvalid` high at N+1.
- There are no registers in the data paths. All channel payloads are combinational pass-through once granted.
- Back-to-back: the last R/B handshake at cycle N puts the FSM in IDLE at N+1. The next grant is visible at N+2.
- Reset is synchronous: at the first clock edge with `rst=1`, the state becomes IDLE and all flags and `beat_cnt` become 0. All outputs are then 0. This also applies mid-transaction; the whole SoC is reset together.

## Structure
- Shared package `ysyx_25020037_axi_pkg` holds:
  - state encodings (2 bits: IDLE=0, RD_IFU=1, RD_LSU=2, WR=3)
  - AXI resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - burst constants (FIXED=0, INCR=1)
- Sub-module `ysyx_25020037_arb_prio`: a combinational 3-input fixed-priority encoder producing the next grant. The top level holds the FSM and the channel muxes.

## Test plan
- IFU-only single read (`addr=0x3000_0000`, `len=0`): `m_arvalid` rises 1 cycle after `ifu_arvalid`. `ifu_rdata` equals `m_rdata`, and `lsu_rvalid` stays 0.
- IFU 4-beat INCR burst (`addr=0xA000_0000`, `len=3`) with `lsu_arvalid` raised at beat 1: the LSU is stalled until the IFU's `rlast`, then granted 2 cycles later. `err_len=0`.
- Simultaneous `ifu_arvalid`, `lsu_arvalid` and `lsu_awvalid` in IDLE: order of service is WR, then RD_LSU, then RD_IFU.
- WR with W before AW (W at cycle 1, AW at cycle 3) and `bresp=SLVERR`: the transaction completes, `lsu_bresp=2`, and the FSM returns to IDLE.
- `rst` pulsed during beat 2 of a 4-beat burst: next cycle the FSM is in IDLE, all valids/readies are 0 and `beat_cnt=0`.
- `m_rlast` asserted on beat 2 of a `len=3` burst: `err_len=1` and the FSM returns to IDLE.
